// File: rtl/cram_store.sv
// ============================================================================
//  Module     : cram_store
//  Description: Control-store RAM with a latency-1 read-first read port and a
//               chunked diagnostic load engine (IDLE/COLLECT/WRITE) that
//               assembles DATA_W-bit microwords from CHUNK_W-bit beats, MSB
//               chunk first, writing at an auto-incrementing pointer.
//               Optional build macro CRAM_PARITY_EN adds one odd-parity bit
//               per stored word with a read-side error flag and sticky latch.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module cram_store #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 84,
    parameter int CHUNK_W = 21
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    input  logic               ld_start,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic               ld_valid,
    input  logic [CHUNK_W-1:0] ld_chunk,
    output logic               ld_ready,
    output logic               ld_busy,
    output logic               ld_done,
    output logic               par_err,
    output logic               par_err_sticky,
    input  logic               par_clr
);

    localparam int C_N_CHUNK = DATA_W / CHUNK_W;
    localparam int C_BEAT_W  = (C_N_CHUNK > 1) ? $clog2(C_N_CHUNK) : 1;
    localparam int C_DEPTH   = 1 << ADDR_W;
    localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(C_N_CHUNK - 1);
`ifdef CRAM_PARITY_EN
    localparam int C_MEM_W   = DATA_W + 1;
`else
    localparam int C_MEM_W   = DATA_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    logic [C_MEM_W-1:0]  mem [0:C_DEPTH-1];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [C_BEAT_W-1:0] beat_q, beat_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                mem_we;
    logic [DATA_W-1:0]   w_word_shift;
    logic [C_MEM_W-1:0]  w_wr_word;
    logic [C_MEM_W-1:0]  w_rd_word;

    // Beats arrive MSB chunk first, so shifting each new chunk in at the
    // bottom leaves beat 0 in the top slice once the word is complete.
    generate
        if (C_N_CHUNK > 1) begin : g_multi_chunk
            assign w_word_shift = {word_q[DATA_W-CHUNK_W-1:0], ld_chunk};
        end else begin : g_single_chunk
            assign w_word_shift = ld_chunk;
        end
    endgenerate

    assign w_rd_word = mem[rd_addr];

`ifdef CRAM_PARITY_EN
    logic par_err_q, par_err_d;
    logic sticky_q, sticky_d;

    // Odd parity: the stored bit makes the total count of ones odd.
    assign w_wr_word = {~^word_q, word_q};

    // Parity check on the read path; set wins over clear on the sticky flag.
    always_comb begin
        par_err_d = rd_en & ~(^w_rd_word);
        sticky_d  = par_err_q | (sticky_q & ~par_clr);
    end

    // Parity status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
            sticky_q  <= sticky_d;
        end
    end

    assign par_err        = par_err_q;
    assign par_err_sticky = sticky_q;
`else
    logic w_unused_par_clr;

    assign w_wr_word        = word_q;
    assign w_unused_par_clr = par_clr;
    assign par_err          = 1'b0;
    assign par_err_sticky   = 1'b0;
`endif

    // Read port: capture the pre-write array contents (read-first), hold otherwise.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = w_rd_word[DATA_W-1:0];
        end
    end

    // Load engine next-state and outputs.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        beat_d   = beat_q;
        word_d   = word_q;
        mem_we   = 1'b0;
        ld_ready = 1'b0;
        ld_busy  = (state_q != S_IDLE);
        ld_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    ptr_d   = ld_addr;
                    beat_d  = '0;
                    state_d = S_COLLECT;
                end else if (ld_valid) begin
                    // Continue at the current pointer; this beat is re-presented.
                    beat_d  = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    word_d = w_word_shift;
                    beat_d = beat_q + C_BEAT_W'(1);
                    if (beat_q == C_LAST_BEAT) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                ld_done = 1'b1;
                ptr_d   = ptr_q + ADDR_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers for the read port and the load engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            beat_q     <= '0;
            word_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array: no reset, written only from the WRITE state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= w_wr_word;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_cram_store.sv
// ============================================================================
//  Module     : tb_cram_store
//  Description: Self-checking bench for cram_store; directed scenarios plus
//               randomized loads/reads against an associative-array model.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cram_store;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 84;
    localparam int CHUNK_W = 21;
    localparam int NCH     = DATA_W / CHUNK_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               rd_en = 1'b0;
    logic [ADDR_W-1:0]  rd_addr = '0;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_valid;
    logic               ld_start = 1'b0;
    logic [ADDR_W-1:0]  ld_addr = '0;
    logic               ld_valid = 1'b0;
    logic [CHUNK_W-1:0] ld_chunk = '0;
    logic               ld_ready;
    logic               ld_busy;
    logic               ld_done;
    logic               par_err;
    logic               par_err_sticky;
    logic               par_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model: word per address, plus the load pointer.
    logic [DATA_W-1:0] model [int];
    int                ptr_m = 0;
    int                written [$];

    cram_store #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .ld_start(ld_start), .ld_addr(ld_addr), .ld_valid(ld_valid), .ld_chunk(ld_chunk),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
        .par_err(par_err), .par_err_sticky(par_err_sticky), .par_clr(par_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [CHUNK_W-1:0] chunk_of(input logic [DATA_W-1:0] w, input int k);
        return w[DATA_W-1-k*CHUNK_W -: CHUNK_W];
    endfunction

    // Load one word; optionally issue a read of rd_a in the WRITE cycle.
    task automatic send_word(input bit use_start, input int addr, input logic [DATA_W-1:0] w,
                             input int gap, input bit rd_at_write, input int rd_a);
        int target;
        int done_cnt;
        logic [DATA_W-1:0] old_val;
        done_cnt = 0;
        if (use_start) begin
            ld_start = 1'b1;
            ld_addr  = addr[ADDR_W-1:0];
            tick();
            ld_start = 1'b0;
            ptr_m    = addr % (1 << ADDR_W);
        end else begin
            ld_valid = 1'b1;
            ld_chunk = chunk_of(w, 0);
            tick();
        end
        check("busy_collect", {83'd0, ld_busy}, 84'd1);
        target = ptr_m;
        for (int k = 0; k < NCH; k++) begin
            ld_valid = 1'b1;
            ld_chunk = chunk_of(w, k);
            check("ready_beat", {83'd0, ld_ready}, 84'd1);
            tick();
            done_cnt += int'(ld_done);
            if (k != NCH - 1) begin
                for (int g = 0; g < gap; g++) begin
                    ld_valid = 1'b0;
                    ld_chunk = '0;
                    check("ready_gap", {83'd0, ld_ready}, 84'd1);
                    tick();
                    done_cnt += int'(ld_done);
                end
            end
        end
        ld_valid = 1'b0;
        check("ready_write", {83'd0, ld_ready}, 84'd0);
        old_val = model.exists(rd_a) ? model[rd_a] : '0;
        if (rd_at_write) begin
            rd_en   = 1'b1;
            rd_addr = rd_a[ADDR_W-1:0];
        end
        tick();
        rd_en = 1'b0;
        done_cnt += int'(ld_done);
        if (rd_at_write && model.exists(rd_a)) begin
            check("read_first_old", rd_data, old_val);
        end
        check("ld_done_once", 84'(done_cnt), 84'd1);
        check("busy_idle", {83'd0, ld_busy}, 84'd0);
        model[target] = w;
        written.push_back(target);
        ptr_m = (target + 1) % (1 << ADDR_W);
    endtask

    task automatic do_read(input string tag, input int a);
        logic [DATA_W-1:0] held;
        rd_en   = 1'b1;
        rd_addr = a[ADDR_W-1:0];
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, {83'd0, rd_valid}, 84'd1);
        check({tag, "_data"}, rd_data, model[a]);
        check({tag, "_perr"}, {83'd0, par_err}, 84'd0);
        held = model[a];
        tick();
        check({tag, "_novalid"}, {83'd0, rd_valid}, 84'd0);
        check({tag, "_hold"}, rd_data, held);
    endtask

    initial begin
        int a;
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] w_old;

        // Reset state
        #12;
        check("rst_rd_data", rd_data, '0);
        check("rst_rd_valid", {83'd0, rd_valid}, 84'd0);
        check("rst_ld_ready", {83'd0, ld_ready}, 84'd0);
        check("rst_ld_busy", {83'd0, ld_busy}, 84'd0);
        check("rst_ld_done", {83'd0, ld_done}, 84'd0);
        check("rst_par_err", {83'd0, par_err}, 84'd0);
        check("rst_sticky", {83'd0, par_err_sticky}, 84'd0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", {83'd0, ld_ready}, 84'd0);

        // Directed load at 0x010
        send_word(1'b1, 'h010, 84'h1ABCD_00001_15555_0AAAA, 0, 1'b0, 0);
        do_read("rd_010", 'h010);

        // Load at 0xFFF then continue without ld_start -> wraps to 0x000
        send_word(1'b1, 'hFFF, 84'h12345_0F0F0_1FFFF_00000, 0, 1'b0, 0);
        send_word(1'b0, 0, 84'h0DEAD_1BEEF_0CAFE_1F00D, 0, 1'b0, 0);
        check("wrap_ptr_model", 84'(ptr_m), 84'd1);
        do_read("rd_fff", 'hFFF);
        do_read("rd_000", 'h000);

        // Gapped beats, exactly NCH beats consumed per word
        send_word(1'b1, 'h100, 84'h11111_02222_13333_04444, 2, 1'b0, 0);
        send_word(1'b0, 0, 84'h05555_16666_07777_18888, 3, 1'b0, 0);
        do_read("rd_100", 'h100);
        do_read("rd_101", 'h101);

        // Reset in the middle of a load to 0x020
        send_word(1'b1, 'h020, 84'h0AAAA_15555_0AAAA_15555, 0, 1'b0, 0);
        ld_start = 1'b1;
        ld_addr  = 12'h020;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1;
            ld_chunk = 21'h1F1F1;
            tick();
        end
        ld_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst_busy", {83'd0, ld_busy}, 84'd0);
        check("midrst_ready", {83'd0, ld_ready}, 84'd0);
        check("midrst_rd_data", rd_data, '0);
        rst_n = 1'b1;
        ptr_m = 0;
        tick();
        tick();
        check("postrst_done", {83'd0, ld_done}, 84'd0);
        do_read("rd_020_kept", 'h020);
        send_word(1'b1, 'h020, 84'h0BEEF_1BEEF_0BEEF_1BEEF, 1, 1'b0, 0);
        do_read("rd_020_new", 'h020);

        // Same-cycle read and write of 0x030
        send_word(1'b1, 'h030, 84'h01234_05678_09ABC_0DEF0, 0, 1'b0, 0);
        send_word(1'b1, 'h030, 84'h1FEDC_1BA98_17654_13210, 0, 1'b1, 'h030);
        do_read("rd_030_new", 'h030);

        // Read independent of an in-progress load
        ld_start = 1'b1;
        ld_addr  = 12'h200;
        tick();
        ld_start = 1'b0;
        ptr_m    = 'h200;
        ld_valid = 1'b1;
        ld_chunk = 21'h00123;
        rd_en    = 1'b1;
        rd_addr  = 12'h010;
        tick();
        rd_en    = 1'b0;
        ld_valid = 1'b0;
        check("rd_during_load", rd_data, model['h010]);
        check("busy_during_rd", {83'd0, ld_busy}, 84'd1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        ptr_m = 0;
        tick();

        // Randomized loads and reads
        for (int i = 0; i < 10; i++) begin
            w = {$urandom, $urandom, $urandom};
            a = int'($urandom_range(0, (1 << ADDR_W) - 1));
            send_word($urandom_range(0, 3) != 0, a, w, int'($urandom_range(0, 2)), 1'b0, 0);
            do_read("rnd_last", written[written.size() - 1]);
            do_read("rnd_any", written[$urandom_range(0, written.size() - 1)]);
        end

`ifdef CRAM_PARITY_EN
        // Corrupt the stored parity bit of 0x040 and read it back
        send_word(1'b1, 'h040, 84'h13579_02468_1ACE0_0BDF1, 0, 1'b0, 0);
        w_old = model['h040];
        dut.mem[12'h040][DATA_W] = ~dut.mem[12'h040][DATA_W];
        rd_en   = 1'b1;
        rd_addr = 12'h040;
        tick();
        rd_en = 1'b0;
        check("par_valid", {83'd0, rd_valid}, 84'd1);
        check("par_err", {83'd0, par_err}, 84'd1);
        check("par_data", rd_data, w_old);
        tick();
        tick();
        check("par_err_drop", {83'd0, par_err}, 84'd0);
        check("sticky_set", {83'd0, par_err_sticky}, 84'd1);
        tick();
        tick();
        check("sticky_hold", {83'd0, par_err_sticky}, 84'd1);
        par_clr = 1'b1;
        tick();
        par_clr = 1'b0;
        check("sticky_clr", {83'd0, par_err_sticky}, 84'd0);
`else
        w_old = '0;
        par_clr = 1'b1;
        tick();
        par_clr = 1'b0;
        check("noparity_sticky", {83'd0, par_err_sticky}, 84'(w_old));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/cram_store.md
CRAM_STORE -- requirements
Module: cram_store

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, control-store address width; depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 84, microword width.
REQ-003 SHALL have parameter CHUNK_W, default 21, diagnostic load beat width; DATA_W SHALL be an integer multiple of CHUNK_W, with N_CHUNK = DATA_W/CHUNK_W.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have port rd_en, input, 1, read request.
REQ-007 SHALL have port rd_addr, input, ADDR_W, read address (CRADR).
REQ-008 SHALL have port rd_data, output, DATA_W, microword read out.
REQ-009 SHALL have port rd_valid, output, 1, rd_data valid this cycle.
REQ-010 SHALL have port ld_start, input, 1, begin a load at ld_addr.
REQ-011 SHALL have port ld_addr, input, ADDR_W, load start address.
REQ-012 SHALL have port ld_valid, input, 1, ld_chunk presented.
REQ-013 SHALL have port ld_chunk, input, CHUNK_W, load beat data.
REQ-014 SHALL have port ld_ready, output, 1, beat accepted when ld_valid and ld_ready are both high.
REQ-015 SHALL have port ld_busy, output, 1, load FSM not IDLE.
REQ-016 SHALL have port ld_done, output, 1, one-cycle pulse per word written.
REQ-017 SHALL have port par_err, output, 1, read parity error, qualified by rd_valid.
REQ-018 SHALL have port par_err_sticky, output, 1, latched parity error.
REQ-019 SHALL have port par_clr, input, 1, clears par_err_sticky.

Function
REQ-020 SHALL read synchronously: rd_en at edge N gives rd_data = mem[rd_addr] and rd_valid=1 after edge N+1 (latency 1).
REQ-021 SHALL hold rd_data when rd_en is low; rd_valid SHALL be 0 in that case.
REQ-022 SHALL, on a same-cycle read and write to the same address, return the old contents (read-first).
REQ-023 SHALL implement the load FSM states IDLE, COLLECT, WRITE.
REQ-024 SHALL, in IDLE with ld_start, capture ld_addr into the load pointer, clear the beat count and enter COLLECT.
REQ-025 SHALL drive ld_ready=1 only in COLLECT.
REQ-026 SHALL place each accepted beat k (0-based) at word bits [DATA_W-1-k*CHUNK_W -: CHUNK_W], MSB chunk first.
REQ-027 SHALL, on accepting beat N_CHUNK-1, enter WRITE.
REQ-028 SHALL, in WRITE, write the assembled word to mem[pointer], pulse ld_done, increment the pointer modulo 2**ADDR_W (max address wraps to 0), and return to IDLE.
REQ-029 SHALL, in IDLE with ld_valid and no ld_start, continue auto-increment: enter COLLECT at the current pointer; this beat is not accepted and is presented again.
REQ-030 SHALL ignore ld_start while in COLLECT or WRITE.
REQ-031 SHALL keep reads fully independent of load activity.

Reset
REQ-032 SHALL, while rst_n=0, force FSM=IDLE, pointer=0, beat count=0, rd_data=0, rd_valid=0, ld_ready=0, ld_busy=0, ld_done=0, par_err=0 and par_err_sticky=0.
REQ-033 SHALL NOT initialise memory contents on reset.
REQ-034 SHALL, on reset during COLLECT or WRITE before the write edge, discard the partial word with no memory write.

Configuration
REQ-035 SHALL, with CRAM_PARITY_EN defined, store one extra odd-parity bit per word over DATA_W bits, computed at WRITE.
REQ-036 SHALL, with CRAM_PARITY_EN defined, set par_err with rd_valid when the stored parity mismatches the read data.
REQ-037 SHALL, with CRAM_PARITY_EN defined, set par_err_sticky on par_err, clear it on par_clr, and give set priority when both occur in the same cycle.
REQ-038 SHALL, without CRAM_PARITY_EN, store no parity bit, tie par_err and par_err_sticky to 0, and ignore par_clr.

Verification
REQ-039 SHALL verify: ld_start with addr 0x010, 4 beats 0x1ABCD, 0x00001, 0x15555, 0x0AAAA; then read 0x010 -> rd_data=84'h1ABCD_00001_15555_0AAAA one cycle later, with ld_done pulsing once.
REQ-040 SHALL verify: after the load at 0xFFF, a second word loaded via ld_valid only (no ld_start) -> it is written at 0x000 (wrap).
REQ-041 SHALL verify: ld_valid held with beats gapped by idle cycles -> ld_ready high throughout COLLECT and exactly 4 beats are consumed per word.
REQ-042 SHALL verify: rst_n pulsed low after beat 2 of a load to 0x020 -> mem[0x020] is unchanged, ld_busy=0, and a new ld_start works.
REQ-043 SHALL verify: read and write of 0x030 in the same cycle -> old data is returned; a read of 0x030 on the next cycle returns the new data.
REQ-044 SHALL verify: with CRAM_PARITY_EN defined, the stored parity bit of 0x040 is forced wrong and the address read -> par_err=1 with rd_valid; par_err_sticky stays 1 until par_clr.
